// File: rtl/kbd_pkg.sv
// kbd_pkg: register offsets, STATUS bit positions and receiver FSM states for ps2_kbd_intc.
package kbd_pkg;
  localparam logic [31:0] DATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam int ST_READY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_PERR = 2;
  localparam int ST_FERR = 3;
  localparam int ST_OVF = 4;
  localparam int ST_CNT = 8;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} kbd_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign count = count_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/ps2_kbd_intc.sv
// ps2_kbd_intc: PS/2 keyboard receiver with scancode FIFO, bus registers and a level interrupt while bytes are pending.
module ps2_kbd_intc import kbd_pkg::*; #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hA000_0000,
  parameter int          TIMEOUT    = 5000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] m_addr,
  input  logic        rmem,
  input  logic        wmem,
  input  logic [31:0] d_t_mem,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        intr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  kbd_state_e state_q, state_d;
  logic [2:0] pc_q, pc_d;
  logic [1:0] pd_q, pd_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d, intr_q, intr_d;
  logic fall, din, push, pop, pop_ok, push_ok, full, empty, is_stat, set_perr, set_ferr;
  logic [2:0] clr;
  logic [7:0] head;
  logic [CW-1:0] count;
  logic [31:0] status;
  logic unused;
  // pc_q[2] is the previous synchronized clock, pc_q[1] the current one
  assign pc_d = {pc_q[1:0], ps2_clk};
  assign pd_d = {pd_q[0], ps2_data};
  assign fall = pc_q[2] & ~pc_q[1];
  assign din = pd_q[1];
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    tmo_d = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
    push = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    if (state_q != IDLE && tmo_q == TW'(TIMEOUT)) begin
      state_d = IDLE;
      tmo_d = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = din ? IDLE : DATA;
          bit_d = '0;
        end
        DATA: begin
          shift_d = {din, shift_q[7:1]};
          bit_d = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          set_ferr = ~din;
          set_perr = din & ~(^{shift_q, par_q});
          push = din & (^{shift_q, par_q});
        end
      endcase
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock), .resetn(resetn), .push(push), .pop(pop), .din(shift_q),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  assign sel = m_addr[31:3] == BASE_ADDR[31:3];
  assign is_stat = m_addr[2] == STATUS_OFS[2];
  assign pop = rmem & sel & ~is_stat;
  assign clr = (wmem & sel & is_stat) ? d_t_mem[ST_OVF:ST_PERR] : 3'b0;
  assign unused = ^{m_addr[1:0], d_t_mem[31:5], d_t_mem[1:0], DATA_OFS};
  always_comb begin
    pop_ok = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    perr_d = set_perr | (perr_q & ~clr[0]);
    ferr_d = set_ferr | (ferr_q & ~clr[1]);
    ovf_d = (push & ~push_ok) | (ovf_q & ~clr[2]);
    intr_d = push_ok | (count > CW'(1)) | (~empty & ~pop_ok);
    status = '0;
    status[ST_READY] = ~empty;
    status[ST_FULL] = full;
    status[ST_PERR] = perr_q;
    status[ST_FERR] = ferr_q;
    status[ST_OVF] = ovf_q;
    status[ST_CNT +: 7] = 7'(count);
    rdata = !sel ? 32'h0 : is_stat ? status : {24'h0, empty ? 8'h0 : head};
  end
  assign intr = intr_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q <= '1;
      pd_q <= '1;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tmo_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pd_q <= pd_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tmo_q <= tmo_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
      intr_q <= intr_d;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_intc.sv
// tb_ps2_kbd_intc: drives PS/2 frames and bus accesses; scoreboard queue holds the bytes expected from DATA reads.
module tb_ps2_kbd_intc;
  localparam logic [31:0] DATA_A = 32'hA000_0000;
  localparam logic [31:0] STAT_A = 32'hA000_0004;
  localparam int TMO = 5000;
  typedef struct {
    logic [7:0]  data;
    logic        pflip;
    logic        sbad;
    logic [31:0] st;
    logic        irq;
  } vec_t;
  logic clock = 0, resetn = 0, ps2_clk = 1, ps2_data = 1, rmem = 0, wmem = 0;
  logic [31:0] m_addr = 0, d_t_mem = 0, rdata, d, op_rd;
  logic sel, intr, intr_pre, intr_post;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[6];
  always #5 clock = ~clock;
  ps2_kbd_intc dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .m_addr(m_addr), .rmem(rmem), .wmem(wmem), .d_t_mem(d_t_mem),
    .sel(sel), .rdata(rdata), .intr(intr)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    m_addr = a;
    rmem = 1;
    #1 v = rdata;
    @(negedge clock);
    rmem = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    m_addr = a;
    d_t_mem = v;
    wmem = 1;
    @(negedge clock);
    wmem = 0;
  endtask
  task automatic rd_pop();
    logic [31:0] e;
    e = exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'h0;
    rd(DATA_A, d);
    chk("data", d, e);
  endtask
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clock);
    ps2_clk = 0;
    repeat (4) @(negedge clock);
    ps2_clk = 1;
  endtask
  // op: 0 none, 1 DATA read on the push edge, 2 STATUS clear on the flag-set edge
  task automatic send_frame(input logic [7:0] b, input logic pflip, input logic sbad, input int op);
    logic [10:0] bits;
    bits = {~sbad, (~^b) ^ pflip, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    ps2_data = bits[10];
    repeat (4) @(negedge clock);
    ps2_clk = 0;
    repeat (2) @(negedge clock);
    intr_pre = intr;
    if (op == 1) begin
      m_addr = DATA_A;
      rmem = 1;
      #1 op_rd = rdata;
    end
    if (op == 2) begin
      m_addr = STAT_A;
      d_t_mem = 32'h1C;
      wmem = 1;
    end
    @(negedge clock);
    rmem = 0;
    wmem = 0;
    intr_post = intr;
    repeat (2) @(negedge clock);
    ps2_clk = 1;
    ps2_data = 1;
    repeat (4) @(negedge clock);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 32'h101, 1'b1};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 32'h004, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 32'h008, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 32'h101, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 32'h101, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 32'h004, 1'b0};
    repeat (3) @(negedge clock);
    chk("intr_in_reset", intr, 0);
    resetn = 1;
    @(negedge clock);
    m_addr = STAT_A;
    #1 chk("sel_hit", sel, 1);
    rd(STAT_A, d);
    chk("status_reset", d, 0);
    rd_pop();
    m_addr = 32'hA000_0008;
    rmem = 1;
    #1 chk("sel_miss", sel, 0);
    chk("rdata_miss", rdata, 0);
    @(negedge clock);
    rmem = 0;
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].pflip, vecs[i].sbad, 0);
      if (vecs[i].irq) begin
        chk("intr_pre", intr_pre, 0);
        chk("intr_post", intr_post, 1);
        exp_q.push_back(vecs[i].data);
      end else chk("intr_err", intr_post, 0);
      rd(STAT_A, d);
      chk("status_vec", d, vecs[i].st);
      if (vecs[i].irq) begin
        rd_pop();
        chk("intr_after_pop", intr, 0);
      end
      wr(STAT_A, vecs[i].st & 32'h1C);
      rd(STAT_A, d);
      chk("status_clr", d, 0);
    end
    send_frame(8'h33, 1'b1, 1'b0, 0);
    send_frame(8'h33, 1'b1, 1'b0, 2);
    rd(STAT_A, d);
    chk("set_wins", d, 32'h4);
    wr(STAT_A, 32'h4);
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b0, 1'b0, 0);
      if (k <= 8) exp_q.push_back(8'(k));
    end
    rd(STAT_A, d);
    chk("status_ovf", d, 32'h813);
    chk("intr_full", intr, 1);
    for (int k = 0; k < 9; k++) rd_pop();
    chk("intr_drained", intr, 0);
    wr(STAT_A, 32'h10);
    rd(STAT_A, d);
    chk("status_drained", d, 0);
    for (int k = 0; k < 8; k++) begin
      send_frame(8'h11 + 8'(k), 1'b0, 1'b0, 0);
      exp_q.push_back(8'h11 + 8'(k));
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1);
    chk("pop_on_push", op_rd, 32'(exp_q.pop_front()));
    exp_q.push_back(8'h5A);
    rd(STAT_A, d);
    chk("status_full_pop", d, 32'h803);
    for (int k = 0; k < 8; k++) rd_pop();
    rd(STAT_A, d);
    chk("status_empty", d, 0);
    ps2_bit(1'b0);
    for (int k = 0; k < 3; k++) ps2_bit(1'b1);
    repeat (TMO + 2) @(negedge clock);
    send_frame(8'hF0, 1'b0, 1'b0, 0);
    exp_q.push_back(8'hF0);
    rd(STAT_A, d);
    chk("status_timeout", d, 32'h101);
    rd_pop();
    ps2_bit(1'b0);
    for (int k = 0; k < 4; k++) ps2_bit(k[0]);
    resetn = 0;
    repeat (2) @(negedge clock);
    chk("intr_mid_reset", intr, 0);
    resetn = 1;
    @(negedge clock);
    send_frame(8'h2B, 1'b0, 1'b0, 0);
    exp_q.push_back(8'h2B);
    rd(STAT_A, d);
    chk("status_after_reset", d, 32'h101);
    rd_pop();
    rd(STAT_A, d);
    chk("status_final", d, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_intc.md
Name: ps2_kbd_intc

Overview:
PS/2 keyboard receiver with a scancode FIFO, memory-mapped on the single-cycle CPU data bus. It is the interrupt-1 source for the CPU: `intr` drives the CPU's keyboard interrupt input. It holds that request while unread scancodes remain. The keyboard handler pops bytes with `lw` and clears error flags with `sw`.

Parameters:
- FIFO_DEPTH, 8, scancode FIFO entries; power of two, 2..64.
- BASE_ADDR, 32'hA000_0000, word-aligned base of the 2-word register window.
- TIMEOUT, 5000, clock cycles without a PS/2 falling edge before an in-progress frame is aborted.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock; asynchronous to `clock`.
- ps2_data  in  1  raw PS/2 data; asynchronous to `clock`.
- m_addr  in  32  CPU data address.
- rmem  in  1  CPU read strobe (combinational, single-cycle).
- wmem  in  1  CPU write strobe.
- d_t_mem  in  32  CPU write data.
- sel  out  1  combinational; high when m_addr[31:3] equals BASE_ADDR[31:3].
- rdata  out  32  combinational read data; valid in the same cycle as `rmem`.
- intr  out  1  registered interrupt request to the CPU.

Behaviour:
- Reset, asynchronous: FSM to IDLE; FIFO empty; sticky flags 0; timeout counter 0; `intr` = 0; synchronizers = 1.
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A falling edge is a third-stage prev=1, cur=0 compare on the synchronized clock. Data is sampled on that edge.
- Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0, go to DATA and clear bit count. Data=1 is ignored.
  - DATA: shift one bit per edge; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: on the next edge, return to IDLE and evaluate the frame.
- Frame evaluation:
  - Stop bit 0: set `ferr`, discard the byte.
  - Else parity check fails (XOR of 8 data bits and parity bit is not 1): set `perr`, discard the byte.
  - Else push the byte to the FIFO on that clock edge.
- Timeout: the counter runs only when the FSM is outside IDLE and is cleared on every falling edge. When it reaches TIMEOUT, the FSM goes to IDLE and the partial byte is discarded; no flag is set.
- FIFO full on push: the byte is dropped and `ovf` is set. Exception: a pop in the same cycle frees a slot, so the push succeeds and the count is unchanged.
- Register map (offset from BASE_ADDR):
  - 0x0 DATA, read: rdata = {24'b0, head byte}. If the FIFO is non-empty and `rmem` & `sel` are high, pop on that clock edge. Reading while empty returns 0 with no pop. Writes are ignored.
  - 0x4 STATUS, read: bit0 ready (non-empty), bit1 full, bit2 perr, bit3 ferr, bit4 ovf, bits[14:8] count (zero-extended); all other bits 0.
  - 0x4 STATUS, write (`wmem` & `sel`): d_t_mem bits 4:2 are write-1-to-clear for perr, ferr, ovf.
- rdata is 0 when `sel` is low.
- Simultaneous flag set and clear in one cycle: the set wins.
- intr is registered as (count != 0) after this edge's push/pop.
  - It rises the cycle after the stop-bit edge pushes the first byte.
  - It falls the cycle after the pop that empties the FIFO.
  - Error flags do not raise intr.
- Addresses and latency: the bus uses word addresses; m_addr[1:0] are ignored. Read access has no added latency.

Decomposition:
- Package `kbd_pkg`:
  - register offsets DATA_OFS = 0, STATUS_OFS = 4;
  - STATUS bit positions;
  - FSM state encoding: 2-bit enum IDLE/DATA/PARITY/STOP.
- Sub-module `sync_fifo`:
  - parameters WIDTH=8, DEPTH;
  - ports push, pop, din, dout (head, combinational), count, full, empty;
  - implements the same-cycle push/pop-when-full rule.
- Top level: synchronizers, FSM, timeout counter, register decode, flags.

Test Plan:
- Reset, then send 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1). Expect intr=1 one cycle after the stop edge and STATUS=0x00000101. `lw` DATA returns 0x0000001C; intr=0 the next cycle; STATUS=0.
- Send 0x1C with parity bit 1. Expect no push, intr stays 0, STATUS=0x4. `sw` 0x4 to STATUS gives STATUS=0.
- Send 9 valid frames (0x01..0x09) with no reads. Expect STATUS=0x00000813 (count 8, ovf, full, ready). The 8 `lw` reads return 0x01..0x08, then the 9th read returns 0 and intr=0.
- With the FIFO full, complete a valid frame 0x5A in the same cycle as a DATA read. Expect the pop to return the old head, count to stay 8, ovf=0, and 0x5A to be the last byte read out.
- Send a start bit plus 3 data bits, then hold ps2_clk high for TIMEOUT+2 cycles, then send a valid 0xF0. Expect exactly one entry, 0xF0, and no flags set.
- Assert resetn=0 mid-frame after 4 data bits, release it, then send 0x2B. Expect a single entry 0x2B and STATUS=0x101.
